fp_mult_execute: RTL

FP_MULT_EXECUTE -- requirements
Module: fp_mult_execute

---
 rtl/fp_mult_if.sv | 35 +++
 rtl/fp_mult_execute.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_if.sv
// Operand/result handshake bundle for fp_mult_execute.
// FPMULT_EXC_FLAGS_EN adds the 4-bit exception flags signal.
interface fp_mult_if;
    logic       in_valid;
    logic       in_ready;
    logic       Sa;
    logic       Sb;
    logic [2:0] Ea;
    logic [2:0] Eb;
    logic [3:0] Ma;
    logic [3:0] Mb;
    logic [4:0] InputExc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
`ifdef FPMULT_EXC_FLAGS_EN
    logic [3:0] flags;
`endif

    modport slave (
        input  in_valid, Sa, Sb, Ea, Eb, Ma, Mb, InputExc, out_ready,
`ifdef FPMULT_EXC_FLAGS_EN
        output flags,
`endif
        output in_ready, out_valid, result
    );

    modport master (
        output in_valid, Sa, Sb, Ea, Eb, Ma, Mb, InputExc, out_ready,
`ifdef FPMULT_EXC_FLAGS_EN
        input  flags,
`endif
        input  in_ready, out_valid, result
    );
endinterface

// File: rtl/fp_mult_execute.sv
// Multi-cycle 8-bit {s, e[2:0], m[3:0]} multiplier: shift-add mantissa product, RNE rounding.
// Optional FPMULT_EXC_FLAGS_EN exposes {overflow, underflow, invalid, inexact} flags.
//
// state | meaning
// IDLE  | waiting for a bundle, in_ready=1
// MULT  | five shift-add steps of {1,Ma}x{1,Mb}
// NORM  | normalise, round, range-check, register result
// DONE  | result presented until out_ready
module fp_mult_execute #(
    parameter int BIAS = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    fp_mult_if.slave    bus
);

    typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

    state_t     state, state_nx;

    logic       s_q;
    logic [2:0] ea_q, eb_q;
    logic [9:0] mcand;
    logic [4:0] mplier;
    logic [9:0] prod;
    logic [2:0] cnt;
    logic [7:0] result_q;
    logic       out_valid_q;

    logic       accept;
    logic       in_nan, in_inf, in_zero, in_exc;
    logic       exc_invalid;
    logic [7:0] exc_result;

    logic       p9;
    logic [3:0] frac;
    logic       guard, sticky, rnd;
    logic [4:0] frac_r;
    logic [4:0] exp_fin;
    logic       ovf, unf, inexact;
    logic [7:0] norm_result;

`ifdef FPMULT_EXC_FLAGS_EN
    logic [3:0] flags_q;
    logic [3:0] exc_flags;
    logic [3:0] norm_flags;
`endif

    assign accept = bus.in_valid && (state == IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = in_exc ? DONE : MULT;
            MULT:    if (cnt == 3'd0) state_nx = NORM;
            NORM:    state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Exceptional operands bypass the multiplier entirely.
    always_comb begin
        in_nan      = bus.InputExc[3] | bus.InputExc[2];
        in_inf      = bus.InputExc[1] | bus.InputExc[0];
        in_zero     = bus.InputExc[4] | (bus.Ea == 3'd0) | (bus.Eb == 3'd0);
        in_exc      = (|bus.InputExc) | (bus.Ea == 3'd0) | (bus.Eb == 3'd0);
        exc_invalid = in_nan | (in_inf & in_zero);
        if (exc_invalid)
            exc_result = 8'h7F;
        else if (in_inf)
            exc_result = {bus.Sa ^ bus.Sb, 7'b111_0000};
        else
            exc_result = {bus.Sa ^ bus.Sb, 7'b000_0000};
    end

    always_comb begin
        p9 = prod[9];
        if (p9) begin
            frac   = prod[8:5];
            guard  = prod[4];
            sticky = |prod[3:0];
        end else begin
            frac   = prod[7:4];
            guard  = prod[3];
            sticky = |prod[2:0];
        end
        rnd     = guard & (sticky | frac[0]);
        frac_r  = {1'b0, frac} + {4'b0000, rnd};
        // frac_r[4] is the 1.1111 -> 10.0000 round carry; fraction wraps to 0000.
        exp_fin = {2'b00, ea_q} + {2'b00, eb_q} - 5'(BIAS)
                  + {4'b0000, p9} + {4'b0000, frac_r[4]};
        inexact = guard | sticky;
        ovf     = 1'b0;
        unf     = 1'b0;
        if ($signed(exp_fin) >= 5'sd7) begin
            ovf         = 1'b1;
            norm_result = {s_q, 7'b111_0000};
        end else if ($signed(exp_fin) <= 5'sd0) begin
            unf         = 1'b1;
            norm_result = {s_q, 7'b000_0000};
        end else begin
            norm_result = {s_q, exp_fin[2:0], frac_r[3:0]};
        end
    end

`ifdef FPMULT_EXC_FLAGS_EN
    always_comb begin
        exc_flags  = {2'b00, exc_invalid, 1'b0};
        norm_flags = {ovf, unf, 1'b0, inexact | ovf | unf};
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_q         <= 1'b0;
            ea_q        <= 3'd0;
            eb_q        <= 3'd0;
            mcand       <= 10'd0;
            mplier      <= 5'd0;
            prod        <= 10'd0;
            cnt         <= 3'd0;
            result_q    <= 8'h00;
            out_valid_q <= 1'b0;
`ifdef FPMULT_EXC_FLAGS_EN
            flags_q     <= 4'd0;
`endif
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (accept) begin
                        s_q    <= bus.Sa ^ bus.Sb;
                        ea_q   <= bus.Ea;
                        eb_q   <= bus.Eb;
                        mcand  <= {5'd0, 1'b1, bus.Ma};
                        mplier <= {1'b1, bus.Mb};
                        prod   <= 10'd0;
                        cnt    <= 3'd4;
                        if (in_exc) begin
                            result_q    <= exc_result;
                            out_valid_q <= 1'b1;
`ifdef FPMULT_EXC_FLAGS_EN
                            flags_q     <= exc_flags;
`endif
                        end
                    end
                end
                MULT: begin
                    if (mplier[0])
                        prod <= prod + mcand;
                    mcand  <= {mcand[8:0], 1'b0};
                    mplier <= {1'b0, mplier[4:1]};
                    if (cnt != 3'd0)
                        cnt <= cnt - 3'd1;
                end
                NORM: begin
                    result_q    <= norm_result;
                    out_valid_q <= 1'b1;
`ifdef FPMULT_EXC_FLAGS_EN
                    flags_q     <= norm_flags;
`endif
                end
                DONE: begin
                    if (bus.out_ready)
                        out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
`ifdef FPMULT_EXC_FLAGS_EN
    assign bus.flags     = flags_q;
`endif

endmodule
